// File: rtl/tlc_lane_request_unit.sv
`default_nettype none
// ============================================================================
// Module   : tlc_lane_request_unit
// Purpose  : Sensor-side companion to the traffic light controller.
//            Synchronises and debounces four raw vehicle detectors, keeps a
//            per-lane call/serve state machine that latches a call until the
//            lane has been served, decodes the controller's 7-segment
//            countdown back to binary and flags illegal lamp/timer codes.
// Ports    :
//   Clock, Reset            - system clock (shared with controller), sync
//                             active-high reset
//   det_e/det_nl/det_el/det_w - raw asynchronous vehicle detectors
//   ETL/NLTL/ELTL/WTL [6:0] - lamp codes from the controller
//   timer [6:0]             - 7-seg countdown code from the controller
//   fault_clear             - clears the sticky code_fault flag
//   E/NL/EL/W               - registered lane requests to the controller
//   timer_val [1:0]         - registered decoded countdown value
//   timer_valid             - registered, 1 when the timer code was legal
//   code_fault              - sticky illegal-code flag
// Revision : 1.0 - initial release
// ============================================================================
module tlc_lane_request_unit #(
  parameter int DEB_CYCLES = 4,
  parameter int DEB_W      = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       det_e,
  input  logic       det_nl,
  input  logic       det_el,
  input  logic       det_w,
  input  logic [6:0] ETL,
  input  logic [6:0] NLTL,
  input  logic [6:0] ELTL,
  input  logic [6:0] WTL,
  input  logic [6:0] timer,
  input  logic       fault_clear,
  output logic       E,
  output logic       NL,
  output logic       EL,
  output logic       W,
  output logic [1:0] timer_val,
  output logic       timer_valid,
  output logic       code_fault
);

  localparam logic [6:0] LAMP_GREEN  = 7'b0010000;
  localparam logic [6:0] LAMP_YELLOW = 7'b0010001;
  localparam logic [6:0] LAMP_RED    = 7'b0101111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CALL    = 2'd1;
  localparam logic [1:0] ST_SERVING = 2'd2;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // Lane index: 0=E, 1=NL, 2=EL, 3=W
  logic [3:0] det_raw;
  logic [6:0] lamp [4];
  logic [3:0] req;
  logic [3:0] lamp_legal;

  assign det_raw = {det_w, det_el, det_nl, det_e};
  assign lamp[0] = ETL;
  assign lamp[1] = NLTL;
  assign lamp[2] = ELTL;
  assign lamp[3] = WTL;

  assign E  = req[0];
  assign NL = req[1];
  assign EL = req[2];
  assign W  = req[3];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic             s1;
    logic             s2;
    logic             deb;
    logic [DEB_W-1:0] cnt;
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             req_q;
    logic             is_green;

    // Illegal lamp codes fall out as not-Green here automatically.
    assign is_green      = (lamp[i] == LAMP_GREEN);
    assign lamp_legal[i] = (lamp[i] == LAMP_GREEN) || (lamp[i] == LAMP_YELLOW) ||
                           (lamp[i] == LAMP_RED);

    // Two-flop synchroniser followed by a run-length debouncer: the level
    // only flips after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge Clock) begin
      if (Reset) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        deb <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= det_raw[i];
        s2 <= s1;
        if (s2 == deb) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DEB_W'(1);
        end
      end
    end

    always_comb begin
      state_nx = state;
      case (state)
        ST_IDLE: begin
          if (deb) state_nx = ST_CALL;
        end
        ST_CALL: begin
          if (is_green)  state_nx = ST_SERVING;
          else if (!deb) state_nx = ST_IDLE;
        end
        ST_SERVING: begin
          if (!deb)           state_nx = ST_IDLE;
          else if (!is_green) state_nx = ST_CALL;
        end
        default: state_nx = ST_IDLE;
      endcase
    end

    // Request is registered alongside the state so it is a clean Moore
    // output with no path from the controller's lamp inputs.
    always_ff @(posedge Clock) begin
      if (Reset) begin
        state <= ST_IDLE;
        req_q <= 1'b0;
      end else begin
        state <= state_nx;
        req_q <= (state_nx != ST_IDLE);
      end
    end

    assign req[i] = req_q;
  end

  logic       tmr_legal;
  logic [1:0] tmr_dec;

  always_comb begin
    tmr_legal = 1'b1;
    tmr_dec   = 2'd0;
    case (timer)
      SEG_0:   tmr_dec = 2'd0;
      SEG_1:   tmr_dec = 2'd1;
      SEG_2:   tmr_dec = 2'd2;
      SEG_3:   tmr_dec = 2'd3;
      default: tmr_legal = 1'b0;
    endcase
  end

  logic fault_set;
  assign fault_set = !tmr_legal || !(&lamp_legal);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      timer_val   <= 2'd0;
      timer_valid <= 1'b0;
      code_fault  <= 1'b0;
    end else begin
      timer_valid <= tmr_legal;
      if (tmr_legal) timer_val <= tmr_dec;
      // Set has priority over clear so a fault in the clearing cycle is kept.
      if (fault_set)        code_fault <= 1'b1;
      else if (fault_clear) code_fault <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/tlc_lane_request_unit.md
Name: tlc_lane_request_unit

Overview:
- Sensor-side companion to the traffic light controller. It produces the controller's lane request inputs (E, NL, EL, W) and consumes the controller's outputs: the four lamp codes and the countdown display.
- Each raw vehicle detector is synchronised and debounced, then feeds a per-lane call/serve state machine. A call is latched until the lane is served.
- The 7-segment timer code is decoded back to a binary value, and illegal lamp or timer codes are flagged.
- Sits between the detector pins and the controller, on the controller's clock.

Parameters:
- DEB_CYCLES, 4, number of consecutive synchronised samples that must differ from the current debounced level before that level flips (legal range 1..15).
- DEB_W, 4, width of each debounce counter.

Ports:
- Clock  input  1  system clock, shared with the controller.
- Reset  input  1  synchronous, active-high.
- det_e, det_nl, det_el, det_w  input  1 each  raw asynchronous vehicle detectors.
- ETL, NLTL, ELTL, WTL  input  7 each  lamp codes from the controller: Green 7'b0010000, Yellow 7'b0010001, Red 7'b0101111.
- timer  input  7  7-seg countdown code: 7'b1000000=0, 7'b1111001=1, 7'b0100100=2, 7'b0110000=3.
- fault_clear  input  1  clears code_fault.
- E, NL, EL, W  output  1 each  registered lane requests to the controller.
- timer_val  output  2  registered decoded countdown value.
- timer_valid  output  1  registered; 1 when the timer code was legal.
- code_fault  output  1  sticky illegal-code flag.

Behaviour:
- Reset (synchronous, active-high):
  - sync flops, debounced levels, counters 0; all lane FSMs IDLE.
  - E/NL/EL/W=0, timer_val=0, timer_valid=0, code_fault=0.
  - Reset asserted mid-operation discards all pending calls on the next edge.
- Synchroniser: two flops per detector. The raw level sampled at edge k appears in s2 after edge k+1.
- Debounce, per lane:
  - If s2 equals the debounced level, the counter clears.
  - Otherwise the counter increments. When the counter equals DEB_CYCLES-1, the debounced level takes s2 and the counter clears.
  - A single-sample mismatch shorter than DEB_CYCLES never flips the level.
- Lane FSM, per lane; the lane's lamp is its own code (E->ETL, NL->NLTL, EL->ELTL, W->WTL). Request is a Moore output: 0 in IDLE, 1 in CALL and SERVING. Transitions:
  - IDLE->CALL when debounced=1.
  - CALL->SERVING when lamp==Green.
  - CALL->IDLE when debounced=0 and lamp!=Green (vehicle left before service).
  - SERVING->IDLE when debounced=0.
  - SERVING->CALL when lamp!=Green and debounced=1 (light left green with vehicle still present).
  - Otherwise the FSM holds.
- Latency: a raw rise stable from edge k gives debounced=1 after edge k+1+DEB_CYCLES and request=1 after edge k+2+DEB_CYCLES. With the default, request rises 6 edges after first sample.
- Lamp and timer inputs are used combinationally. All outputs are registered, so no combinational loop exists with the controller (its outputs depend on its state only).
- Timer decode:
  - Each edge, timer_val gets the decoded value and timer_valid=1 when the code is in the table.
  - For an illegal code, timer_valid=0 and timer_val holds its previous value.
- code_fault:
  - Set at the next edge when any lamp code is not in {Green, Yellow, Red}, or timer is illegal.
  - Cleared by fault_clear. If set and clear occur in the same cycle, set wins.
  - Illegal lamp code: the lane FSM treats it as not-Green.
- Simultaneous calls on all lanes are independent; there is no arbitration, which is the controller's job.

Test Plan:
- Reset with det_e=1 held: E=0 throughout reset. After release, E=1 exactly 6 edges after first sample (DEB_CYCLES=4); other requests stay 0.
- det_nl glitch high for 3 cycles, then low: NL never asserts; debounce counter returns to 0.
- det_w=1 with WTL=Red: W=1 (CALL). WTL=Green: FSM goes SERVING, W stays 1. det_w low for 4+2 cycles: W=0 (IDLE).
- det_el=1 held, ELTL goes Green->Yellow: EL stays 1 (SERVING->CALL). ELTL Green again, then det_el drops: EL=0.
- Sweep timer through the 4 legal codes: timer_val=0,1,2,3 and timer_valid=1, each one edge later. timer=7'b1111111: timer_valid=0, timer_val held, code_fault=1. fault_clear pulse alone: code_fault=0. fault_clear together with another illegal code: code_fault stays 1.
- All four detectors high, then Reset pulsed for one cycle mid-CALL: all requests 0 next edge, then re-assert DEB_CYCLES+2 edges after Reset drops.
